// File: rtl/rtc_clint_pkg.sv
// Shared definitions for the machine timer / software-interrupt block:
// register offsets, interrupt cause codes and the byte-lane merge helper.
package rtc_clint_pkg;

  typedef enum logic [4:0] {
    MSIP_OFF        = 5'h00,
    MTIMECMP_LO_OFF = 5'h08,
    MTIMECMP_HI_OFF = 5'h0C,
    MTIME_LO_OFF    = 5'h10,
    MTIME_HI_OFF    = 5'h14
  } reg_off_e;

  typedef enum logic [3:0] {
    U_SW_INT  = 4'd0,
    S_SW_INT  = 4'd1,
    M_SW_INT  = 4'd3,
    U_TIM_INT = 4'd4,
    S_TIM_INT = 4'd5,
    M_TIM_INT = 4'd7,
    U_EXT_INT = 4'd8,
    S_EXT_INT = 4'd9,
    M_EXT_INT = 4'd11
  } interruptionCode_e;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
      else       res[8*k +: 8] = old_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE cycles; PRESCALE=1 ticks
// every cycle with no counter.
module rtc_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_o
);

  if (PRESCALE == 1) begin : g_nodiv
    logic w_unused_clk;
    assign w_unused_clk = &{1'b0, clk, reset_n};
    assign tick_o = 1'b1;
  end else begin : g_div
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    logic [CW-1:0] r_cnt;

    // Free-running divide counter, wraps after the tick cycle
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    assign tick_o = (r_cnt == LAST);
  end

endmodule

// File: rtl/rtc_clint.sv
// Memory-mapped machine timer (mtime/mtimecmp) and software interrupt (msip)
// responder on the data bus.
module rtc_clint
  import rtc_clint_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en_i,
  input  logic [3:0]  we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        mti_o,
  output logic        msi_o,
  output logic [63:0] mtime_o
);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic [31:0] r_data;

  logic        w_tick;
  logic        w_wr;
  logic        w_rd;
  logic [4:0]  w_off;
  logic [63:0] w_mtime_nxt;
  logic [63:0] w_cmp_nxt;
  logic        w_msip_nxt;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  rtc_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_o  (w_tick)
  );

  assign w_wr          = en_i && (we_i != 4'b0000);
  assign w_rd          = en_i && (we_i == 4'b0000);
  assign w_off         = {addr_i[4:2], 2'b00};
  assign w_unused_addr = &{1'b0, addr_i[1:0]};

  // Register next-state: a bus write to mtime replaces the increment entirely
  always_comb begin
    w_mtime_nxt = w_tick ? (r_mtime + 64'd1) : r_mtime;
    w_cmp_nxt   = r_mtimecmp;
    w_msip_nxt  = r_msip;
    if (w_wr) begin
      case (w_off)
        MSIP_OFF:        w_msip_nxt = we_i[0] ? data_i[0] : r_msip;
        MTIMECMP_LO_OFF: w_cmp_nxt = {r_mtimecmp[63:32], merge_bytes(r_mtimecmp[31:0], data_i, we_i)};
        MTIMECMP_HI_OFF: w_cmp_nxt = {merge_bytes(r_mtimecmp[63:32], data_i, we_i), r_mtimecmp[31:0]};
        MTIME_LO_OFF:    w_mtime_nxt = {r_mtime[63:32], merge_bytes(r_mtime[31:0], data_i, we_i)};
        MTIME_HI_OFF:    w_mtime_nxt = {merge_bytes(r_mtime[63:32], data_i, we_i), r_mtime[31:0]};
        default:         w_msip_nxt = r_msip;
      endcase
    end else begin
      w_msip_nxt = r_msip;
    end
  end

  // Read mux
  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      MSIP_OFF:        w_rdata = {31'd0, r_msip};
      MTIMECMP_LO_OFF: w_rdata = r_mtimecmp[31:0];
      MTIMECMP_HI_OFF: w_rdata = r_mtimecmp[63:32];
      MTIME_LO_OFF:    w_rdata = r_mtime[31:0];
      MTIME_HI_OFF:    w_rdata = r_mtime[63:32];
      default:         w_rdata = 32'd0;
    endcase
  end

  // State registers; read data holds its value between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= MTIMECMP_RST;
      r_msip     <= 1'b0;
      r_data     <= 32'd0;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_cmp_nxt;
      r_msip     <= w_msip_nxt;
      if (w_rd) r_data <= w_rdata;
      else      r_data <= r_data;
    end
  end

  assign data_o  = r_data;
  assign mti_o   = (r_mtime >= r_mtimecmp);
  assign msi_o   = r_msip;
  assign mtime_o = r_mtime;

endmodule

// File: tb/tb_rtc_clint.sv
// Scoreboard bench for rtc_clint: one instance with PRESCALE=1, one with
// PRESCALE=4, sharing the bus stimulus.
module tb_rtc_clint;

  logic        clk;
  logic        reset_n;
  logic        en_i;
  logic [3:0]  we_i;
  logic [4:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] d1, d4;
  logic        mti1, msi1, mti4, msi4;
  logic [63:0] mt1, mt4;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  rtc_clint #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(d1), .mti_o(mti1), .msi_o(msi1), .mtime_o(mt1));

  rtc_clint #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(d4), .mti_o(mti4), .msi_o(msi4), .mtime_o(mt4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset_n = 1'b0; en_i = 1'b0; we_i = 4'b0000; addr_i = 5'h00; data_i = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    en_i = 1'b1; we_i = be; addr_i = a; data_i = d;
    @(posedge clk);
    #1;
    en_i = 1'b0; we_i = 4'b0000;
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] ex);
    @(negedge clk);
    en_i = 1'b1; we_i = 4'b0000; addr_i = a;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    en_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (mt1 !== 64'd0) begin n_err++; $display("FAIL rst_mtime: got %h want 0", mt1); end
    n_vec++; if (mti1 !== 1'b0 || mti4 !== 1'b0) begin n_err++; $display("FAIL rst_mti: got %b/%b want 0", mti1, mti4); end
    n_vec++; if (msi1 !== 1'b0) begin n_err++; $display("FAIL rst_msi: got %b want 0", msi1); end
    n_vec++; if (d1 !== 32'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", d1); end
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(5'h08, 32'hFFFF_FFFF);
    e = exp_q.pop_front();
    n_vec++; if (d4 !== e || d1 !== e) begin n_err++; $display("FAIL rst_cmp_lo: got %h/%h want %h", d4, d1, e); end
    bus_read(5'h0C, 32'hFFFF_FFFF);
    e = exp_q.pop_front();
    n_vec++; if (d4 !== e) begin n_err++; $display("FAIL rst_cmp_hi: got %h want %h", d4, e); end
    bus_read(5'h10, 32'h0000_0000);
    e = exp_q.pop_front();
    n_vec++; if (d4 !== e) begin n_err++; $display("FAIL rst_mtime_lo: got %h want %h", d4, e); end
  endtask

  task automatic test_prescale();
    apply_reset();
    repeat (40) @(posedge clk);
    #1;
    n_vec++; if (mt4 !== 64'd10) begin n_err++; $display("FAIL presc_mtime4: got %0d want 10", mt4); end
    n_vec++; if (mt1 !== 64'd40) begin n_err++; $display("FAIL presc_mtime1: got %0d want 40", mt1); end
    bus_read(5'h10, 32'd10);
    e = exp_q.pop_front();
    n_vec++; if (d4 !== e) begin n_err++; $display("FAIL presc_read: got %h want %h", d4, e); end
  endtask

  task automatic test_timer_irq();
    apply_reset();
    bus_write(5'h08, 4'b1111, 32'd5);
    bus_write(5'h0C, 4'b1111, 32'd0);
    n_vec++; if (mt1 !== 64'd3 || mti1 !== 1'b0) begin n_err++; $display("FAIL irq_at3: got %0d/%b want 3/0", mt1, mti1); end
    @(posedge clk); #1;
    n_vec++; if (mt1 !== 64'd4 || mti1 !== 1'b0) begin n_err++; $display("FAIL irq_at4: got %0d/%b want 4/0", mt1, mti1); end
    @(posedge clk); #1;
    n_vec++; if (mt1 !== 64'd5 || mti1 !== 1'b1) begin n_err++; $display("FAIL irq_at5: got %0d/%b want 5/1", mt1, mti1); end
    bus_write(5'h08, 4'b1111, 32'hFFFF_FFFF);
    n_vec++; if (mti1 !== 1'b0) begin n_err++; $display("FAIL irq_fall: got %b want 0", mti1); end
  endtask

  task automatic test_mtime_carry();
    apply_reset();
    bus_write(5'h10, 4'b1111, 32'hFFFF_FFFF);
    bus_write(5'h14, 4'b1111, 32'h0000_0000);
    n_vec++; if (mt1 !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL carry_pre: got %h want 00000000ffffffff", mt1); end
    @(posedge clk); #1;
    n_vec++; if (mt1 !== 64'h0000_0001_0000_0000) begin n_err++; $display("FAIL carry: got %h want 0000000100000000", mt1); end
    bus_write(5'h10, 4'b1111, 32'hFFFF_FFFF);
    bus_write(5'h14, 4'b1111, 32'hFFFF_FFFF);
    n_vec++; if (mt1 !== 64'hFFFF_FFFF_FFFF_FFFF || mti1 !== 1'b1) begin n_err++; $display("FAIL wrap_pre: got %h/%b want all-ones/1", mt1, mti1); end
    @(posedge clk); #1;
    n_vec++; if (mt1 !== 64'd0 || mti1 !== 1'b0) begin n_err++; $display("FAIL wrap: got %h/%b want 0/0", mt1, mti1); end
  endtask

  task automatic test_write_vs_tick();
    apply_reset();
    repeat (3) @(posedge clk);
    bus_write(5'h10, 4'b1111, 32'h0000_0100);
    n_vec++; if (mt4 !== 64'h100) begin n_err++; $display("FAIL wtick_p4: got %h want 100", mt4); end
    n_vec++; if (mt1 !== 64'h100) begin n_err++; $display("FAIL wtick_p1: got %h want 100", mt1); end
    repeat (4) @(posedge clk);
    #1;
    n_vec++; if (mt4 !== 64'h101) begin n_err++; $display("FAIL wtick_next4: got %h want 101", mt4); end
    n_vec++; if (mt1 !== 64'h104) begin n_err++; $display("FAIL wtick_next1: got %h want 104", mt1); end
  endtask

  task automatic test_msip_and_map();
    apply_reset();
    bus_write(5'h00, 4'b0001, 32'h0000_0001);
    n_vec++; if (msi1 !== 1'b1) begin n_err++; $display("FAIL msip_set: got %b want 1", msi1); end
    bus_read(5'h00, 32'h0000_0001);
    e = exp_q.pop_front();
    n_vec++; if (d1 !== e) begin n_err++; $display("FAIL msip_read: got %h want %h", d1, e); end
    @(posedge clk); #1;
    n_vec++; if (d1 !== 32'h0000_0001) begin n_err++; $display("FAIL data_hold: got %h want 1", d1); end
    bus_write(5'h00, 4'b1111, 32'hFFFF_FFFF);
    bus_read(5'h00, 32'h0000_0001);
    e = exp_q.pop_front();
    n_vec++; if (d1 !== e) begin n_err++; $display("FAIL msip_upper: got %h want %h", d1, e); end
    bus_write(5'h00, 4'b1111, 32'h0000_0000);
    n_vec++; if (msi1 !== 1'b0) begin n_err++; $display("FAIL msip_clr: got %b want 0", msi1); end
    bus_write(5'h0C, 4'b0010, 32'h1234_5678);
    bus_read(5'h0C, 32'hFFFF_56FF);
    e = exp_q.pop_front();
    n_vec++; if (d1 !== e) begin n_err++; $display("FAIL byte_lane: got %h want %h", d1, e); end
    bus_read(5'h0E, 32'hFFFF_56FF);
    e = exp_q.pop_front();
    n_vec++; if (d1 !== e) begin n_err++; $display("FAIL addr_low_bits: got %h want %h", d1, e); end
    bus_write(5'h18, 4'b1111, 32'hDEAD_BEEF);
    bus_read(5'h18, 32'h0000_0000);
    e = exp_q.pop_front();
    n_vec++; if (d1 !== e) begin n_err++; $display("FAIL unmapped_18: got %h want %h", d1, e); end
    bus_read(5'h04, 32'h0000_0000);
    e = exp_q.pop_front();
    n_vec++; if (d1 !== e) begin n_err++; $display("FAIL unmapped_04: got %h want %h", d1, e); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus_write(5'h0C, 4'b1111, 32'h0000_0000);
    bus_write(5'h08, 4'b1111, 32'h0000_0000);
    n_vec++; if (mti1 !== 1'b1) begin n_err++; $display("FAIL ar_pre_mti: got %b want 1", mti1); end
    bus_write(5'h00, 4'b0001, 32'h0000_0001);
    bus_read(5'h10, 32'd4);
    e = exp_q.pop_front();
    n_vec++; if (d1 !== e) begin n_err++; $display("FAIL ar_pre_read: got %h want %h", d1, e); end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++; if (mti1 !== 1'b0 || msi1 !== 1'b0) begin n_err++; $display("FAIL ar_irq: got %b/%b want 0/0", mti1, msi1); end
    n_vec++; if (mt1 !== 64'd0 || mt4 !== 64'd0) begin n_err++; $display("FAIL ar_mtime: got %h/%h want 0/0", mt1, mt4); end
    n_vec++; if (d1 !== 32'd0 || d4 !== 32'd0) begin n_err++; $display("FAIL ar_data: got %h/%h want 0/0", d1, d4); end
    n_vec++; if (mti4 !== 1'b0 || msi4 !== 1'b0) begin n_err++; $display("FAIL ar_irq4: got %b/%b want 0/0", mti4, msi4); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    en_i    = 1'b0;
    we_i    = 4'b0000;
    addr_i  = 5'h00;
    data_i  = 32'd0;
    test_reset();
    test_prescale();
    test_timer_irq();
    test_mtime_carry();
    test_write_vs_tick();
    test_msip_and_map();
    test_async_reset();
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
